// File: rtl/writeback_regfile_pkg.sv
// Shared pipeline definitions for the writeback stage and register file:
// data/address widths, the zero register index and the MemToReg source codes.
// Optional feature macro used by the register file: WB_BYPASS_EN.
package writeback_regfile_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  // MemToReg encodings; code 3 is reserved and selects zero.
  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'd0,
    WB_SRC_MEM  = 2'd1,
    WB_SRC_LINK = 2'd2,
    WB_SRC_RSVD = 2'd3
  } wb_src_e;

  // A writeback commits only when enabled, outside reset, and not aimed at r0.
  function automatic logic wb_commits(input logic                  reg_write,
                                      input logic                  reset,
                                      input logic [REG_ADDR_W-1:0] reg_rd);
    return reg_write && !reset && (reg_rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/writeback_regfile_wb_mux.sv
// Writeback source select: picks the ALU result, load data or the link value
// (PC+4) according to the MemToReg code. The reserved code yields zero.
module wb_mux
  import writeback_regfile_pkg::*;
(
  input  logic [1:0]        mem_to_reg,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [DATA_W-1:0] pc_add_result,
  output logic [DATA_W-1:0] write_data
);

  // Pure combinational source select.
  always_comb begin
    write_data = '0;
    case (wb_src_e'(mem_to_reg))
      WB_SRC_ALU:  write_data = alu_result;
      WB_SRC_MEM:  write_data = mem_read_data;
      WB_SRC_LINK: write_data = pc_add_result;
      default:     write_data = '0;
    endcase
  end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage plus 32x32 register file with two combinational read ports.
// r0 is hard-wired to zero. Reset is synchronous, active-high, and wins over
// a same-edge write. There is no handshake: every input is consumed each cycle.
// Define WB_BYPASS_EN to forward the in-flight writeback value to a read port
// addressing the same nonzero register in the same cycle; without it a write
// becomes visible the cycle after its edge.
module writeback_regfile
  import writeback_regfile_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [DATA_W-1:0]     PCAddResult,
  input  logic [DATA_W-1:0]     MemReadData,
  input  logic [DATA_W-1:0]     ALUResult,
  input  logic [REG_ADDR_W-1:0] RegRd,
  input  logic                  RegWrite,
  input  logic [1:0]            MemToReg,
  input  logic [REG_ADDR_W-1:0] ReadRegister1,
  input  logic [REG_ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0]     ReadData1,
  output logic [DATA_W-1:0]     ReadData2,
  output logic [DATA_W-1:0]     WriteData
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_live;
  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rf_rd2;

  wb_mux u_wb_mux (
    .mem_to_reg    (MemToReg),
    .alu_result    (ALUResult),
    .mem_read_data (MemReadData),
    .pc_add_result (PCAddResult),
    .write_data    (WriteData)
  );

  assign wr_live = wb_commits(RegWrite, Reset, RegRd);

  // Next register-file contents: apply the committing write, keep r0 at zero.
  always_comb begin
    regs_d = regs_q;
    if (wr_live) begin
      regs_d[RegRd] = WriteData;
    end
    regs_d[REG_ZERO] = '0;
  end

  // Register-file state; reset clears every entry and drops any write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Stored-value lookup; r0 forced to zero even before the first reset.
  always_comb begin
    rf_rd1 = '0;
    rf_rd2 = '0;
    if (ReadRegister1 != REG_ZERO) begin
      rf_rd1 = regs_q[ReadRegister1];
    end
    if (ReadRegister2 != REG_ZERO) begin
      rf_rd2 = regs_q[ReadRegister2];
    end
  end

  // Read ports, optionally forwarding the in-flight writeback.
  always_comb begin
    ReadData1 = rf_rd1;
    ReadData2 = rf_rd2;
`ifdef WB_BYPASS_EN
    if (wr_live && (ReadRegister1 == RegRd)) begin
      ReadData1 = WriteData;
    end
    if (wr_live && (ReadRegister2 == RegRd)) begin
      ReadData2 = WriteData;
    end
`endif
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed scenarios followed by random traffic.
// A reference model (plain array of register values) predicts the read ports
// and WriteData for each cycle; predictions go into a queue and a monitor on
// the falling edge pops and compares them.
module tb_writeback_regfile;

  logic        Clk;
  logic        Reset;
  logic [31:0] PCAddResult;
  logic [31:0] MemReadData;
  logic [31:0] ALUResult;
  logic [4:0]  RegRd;
  logic        RegWrite;
  logic [1:0]  MemToReg;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WriteData;

  writeback_regfile dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .PCAddResult   (PCAddResult),
    .MemReadData   (MemReadData),
    .ALUResult     (ALUResult),
    .RegRd         (RegRd),
    .RegWrite      (RegWrite),
    .MemToReg      (MemToReg),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .WriteData     (WriteData)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- scoreboard state ----------------
  logic [95:0] exp_q [$];
  string       tag_q [$];
  logic [31:0] model [32];
  bit          obs_valid;
  int          checks;
  int          errors;

  // ---------------- driver ----------------
  // Applies one cycle of inputs, queues the expected outputs for the monitor,
  // then crosses the rising edge and advances the model.
  task automatic drive(input bit rst, input bit we, input logic [1:0] m2r,
                       input logic [4:0] rd, input logic [4:0] ra1,
                       input logic [4:0] ra2, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc,
                       input bit chk, input string tag);
    logic [31:0] wd, e1, e2;
    bit          commits;
    Reset = rst; RegWrite = we; MemToReg = m2r; RegRd = rd;
    ReadRegister1 = ra1; ReadRegister2 = ra2;
    ALUResult = alu; MemReadData = mem; PCAddResult = pc;
    case (m2r)
      2'd0:    wd = alu;
      2'd1:    wd = mem;
      2'd2:    wd = pc;
      default: wd = 32'h0;
    endcase
    commits = we && !rst && (rd != 5'd0);
    e1 = (ra1 == 5'd0) ? 32'h0 : model[ra1];
    e2 = (ra2 == 5'd0) ? 32'h0 : model[ra2];
`ifdef WB_BYPASS_EN
    if (commits && ra1 == rd) e1 = wd;
    if (commits && ra2 == rd) e2 = wd;
`endif
    obs_valid = chk;
    if (chk) begin
      exp_q.push_back({e1, e2, wd});
      tag_q.push_back(tag);
    end
    @(posedge Clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (commits) begin
      model[rd] = wd;
    end
    #1;
  endtask

  // Idle read-only cycle.
  task automatic read_pair(input logic [4:0] ra1, input logic [4:0] ra2,
                           input string tag);
    drive(1'b0, 1'b0, 2'd0, 5'd0, ra1, ra2, 32'h0, 32'h0, 32'h0, 1'b1, tag);
  endtask

  // ---------------- monitor ----------------
  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (obs_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow actual=empty expected=entry t=%0t", $time);
      end else begin
        logic [95:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        cmp({t, ".rd1"}, ReadData1, e[95:64]);
        cmp({t, ".rd2"}, ReadData2, e[63:32]);
        cmp({t, ".wd"},  WriteData, e[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; errors = 0; obs_valid = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    Reset = 1'b1; RegWrite = 1'b0; MemToReg = 2'd0; RegRd = 5'd0;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
    ALUResult = 32'h0; MemReadData = 32'h0; PCAddResult = 32'h0;

    // Reset for one edge, then every index reads zero.
    drive(1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, "reset");
    for (int i = 0; i < 16; i++) read_pair(5'(2*i), 5'(2*i+1), "reset_read");

    // ALU writeback to r8, then read it back on both ports.
    drive(1'b0, 1'b1, 2'd0, 5'd8, 5'd1, 5'd2, 32'h0000_00A5, 32'h1111_1111,
          32'h2222_2222, 1'b1, "wr_r8");
    read_pair(5'd8, 5'd8, "rd_r8");

    // Memory writeback to r9, link writeback to r31.
    drive(1'b0, 1'b1, 2'd1, 5'd9, 5'd0, 5'd8, 32'h3333_3333, 32'hDEAD_BEEF,
          32'h4444_4444, 1'b1, "wr_r9");
    drive(1'b0, 1'b1, 2'd2, 5'd31, 5'd9, 5'd0, 32'h5555_5555, 32'h6666_6666,
          32'h0000_0104, 1'b1, "wr_r31");
    read_pair(5'd9, 5'd31, "rd_r9_r31");

    // Reserved source code selects zero (no write).
    drive(1'b0, 1'b0, 2'd3, 5'd0, 5'd9, 5'd8, 32'hAAAA_AAAA, 32'hBBBB_BBBB,
          32'hCCCC_CCCC, 1'b1, "src_rsvd");

    // Write to r0 is ignored.
    drive(1'b0, 1'b1, 2'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0,
          1'b1, "wr_r0");
    read_pair(5'd0, 5'd31, "rd_r0");

    // Same-cycle write and read of r5.
    drive(1'b0, 1'b1, 2'd0, 5'd5, 5'd5, 5'd5, 32'h0BAD_0005, 32'h0, 32'h0,
          1'b1, "pre_r5");
    drive(1'b0, 1'b1, 2'd0, 5'd5, 5'd0, 5'd5, 32'h1234_5678, 32'h0, 32'h0,
          1'b1, "same_cyc_r5");
    read_pair(5'd5, 5'd5, "rd_r5");

    // Reset and write on the same edge: write dropped; reads before the edge
    // still show the stored state.
    drive(1'b0, 1'b1, 2'd0, 5'd3, 5'd3, 5'd8, 32'h0000_0077, 32'h0, 32'h0,
          1'b1, "pre_r3");
    drive(1'b1, 1'b1, 2'd0, 5'd3, 5'd3, 5'd5, 32'h0000_0055, 32'h0, 32'h0,
          1'b1, "rst_wr_r3");
    read_pair(5'd3, 5'd5, "rd_after_rst");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] rd, ra1, ra2;
      rd  = 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), rd, ra1, ra2,
            $urandom, $urandom, $urandom, 1'b1, "rand");
    end

    obs_valid = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port PCAddResult  input  32  PC+4 from the MEM/WB stage, used as link value.
REQ-004 SHALL have port MemReadData  input  32  load data from the MEM/WB stage.
REQ-005 SHALL have port ALUResult  input  32  ALU result from the MEM/WB stage.
REQ-006 SHALL have port RegRd  input  5  destination register index.
REQ-007 SHALL have port RegWrite  input  1  write enable for the current writeback.
REQ-008 SHALL have port MemToReg  input  2  writeback source: 0 ALU, 1 memory, 2 link (PCAddResult), 3 reserved.
REQ-009 SHALL have ports ReadRegister1 and ReadRegister2  input  5 each  decode-stage read indices.
REQ-010 SHALL have ports ReadData1 and ReadData2  output  32 each  decode-stage read data.
REQ-011 SHALL have port WriteData  output  32  selected writeback value, exported for forwarding.

Function
REQ-012 SHALL select WriteData combinationally from MemToReg; code 3 SHALL yield 32'h0.
REQ-013 SHALL hold 32 registers of 32 bits; register 0 SHALL read 0 always and ignore writes.
REQ-014 SHALL write WriteData into register RegRd on the rising Clk edge when RegWrite=1, RegRd!=0, and Reset=0.
REQ-015 SHALL drive ReadData1/2 combinationally from the indexed register (zero latency after the address changes).
REQ-016 A write SHALL become visible on the read ports in the cycle after its edge (one-cycle write latency) when bypass is compiled out.
REQ-017 Simultaneous write and read of the same nonzero index with bypass compiled out SHALL return the old value.
REQ-018 Both read ports SHALL operate independently, including when both use the same index.
REQ-019 RegWrite=1 with RegRd=0 SHALL leave all state unchanged.

Reset
REQ-020 Reset=1 at a rising edge SHALL clear all 32 registers to 0.
REQ-021 Reset SHALL take priority over a same-cycle write; that write SHALL be dropped.
REQ-022 Reset SHALL be sampled only on Clk edges; asserting it between edges SHALL change nothing until the next edge.
REQ-023 WriteData SHALL remain combinational from the inputs during reset; ReadData1/2 SHALL read 0 after the reset edge.

Configuration
REQ-024 SHALL compile in internal write-to-read bypass when macro WB_BYPASS_EN is defined.
REQ-025 With WB_BYPASS_EN defined, each read port matching a nonzero RegRd while RegWrite=1 and Reset=0 SHALL return WriteData in the same cycle.
REQ-026 Without WB_BYPASS_EN, the read behaviour SHALL be exactly as REQ-016/REQ-017.

Structure
REQ-027 SHALL place the MemToReg encodings (WB_SRC_ALU=0, WB_SRC_MEM=1, WB_SRC_LINK=2), REG_ADDR_W=5, DATA_W=32, and REG_ZERO=0 in the shared pipeline package.
REQ-028 SHALL instantiate one sub-module, wb_mux, which is the combinational writeback source select.

Verification
REQ-029 SHALL cover this scenario: Reset for one edge, then read all indices -> every ReadData equals 0.
REQ-030 SHALL cover this scenario: RegWrite=1, RegRd=8, MemToReg=0, ALUResult=32'h0000_00A5 -> after the edge, ReadRegister1=8 returns 32'h0000_00A5.
REQ-031 SHALL cover this scenario: MemToReg=1, MemReadData=32'hDEAD_BEEF, RegRd=9; MemToReg=2, PCAddResult=32'h0000_0104, RegRd=31 -> R9=32'hDEAD_BEEF and R31=32'h0000_0104.
REQ-032 SHALL cover this scenario: RegWrite=1, RegRd=0, ALUResult=32'hFFFF_FFFF -> R0 still reads 0.
REQ-033 SHALL cover this scenario: same-cycle write of R5=32'h1234_5678 with ReadRegister2=5 -> old value without WB_BYPASS_EN and 32'h1234_5678 with it.
REQ-034 SHALL cover this scenario: Reset=1 and a write of R3=32'h55 on the same edge -> R3 reads 0 afterwards.
